// File: rtl/intpol2_dn_nxt_ste_lgc.sv
// rtl/intpol2_dn_nxt_ste_lgc.sv - interpolator coefficient-load, channel/sample sequencing and bypass registers
module intpol2_dn_nxt_ste_lgc #(
    parameter int CONFIG_WIDTH   = 32,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int NUM_CH         = 2,
    parameter int N_COEF         = 3,
    parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int SEL_W          = $clog2(N_COEF + 1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clear,
    input  logic                      start,
    input  logic                      busy,
    input  logic                      Empty,
    input  logic                      Afull,
    input  logic                      en_sum,
    input  logic                      Read_Enable,
    input  logic                      Write_Enable,
    input  logic                      done,
    input  logic [CONFIG_WIDTH-1:0]   ilen,
    input  logic [CONFIG_WIDTH-1:0]   ylen,
    output logic [MEM_ADDR_WIDTH-1:0] M_addr,
    output logic [N_COEF-1:0]         ld_m,
    output logic [CH_W-1:0]           ld_ch,
    output logic                      coef_ready,
    output logic [CH_W-1:0]           ch_idx,
    output logic [SEL_W-1:0]          sel_xi,
    output logic                      comp_cnt,
    output logic [MEM_ADDR_WIDTH-1:0] Y_addr,
    output logic [MEM_ADDR_WIDTH-1:0] Y_addr_bypass,
    output logic                      Write_bypass_mem,
    output logic                      FIFO_bypass
);

    localparam int CNT_W = CONFIG_WIDTH + 1;
    localparam logic [MEM_ADDR_WIDTH-1:0] LP_M_LAST   = MEM_ADDR_WIDTH'(NUM_CH * N_COEF - 1);
    localparam logic [SEL_W-1:0]          LP_TAP_LAST = SEL_W'(N_COEF - 1);
    localparam logic [CH_W-1:0]           LP_CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]          LP_NCOEF    = CNT_W'(N_COEF);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LAST, S_RUN} state_t;

    state_t                    r_state;
    logic [MEM_ADDR_WIDTH-1:0] r_m_addr;
    logic [SEL_W-1:0]          r_tap;
    logic [CH_W-1:0]           r_lch;
    logic [N_COEF-1:0]         r_ld_m;
    logic [CH_W-1:0]           r_ld_ch;
    logic [CH_W-1:0]           r_ch_idx;
    logic [CNT_W-1:0]          r_cnt;
    logic [MEM_ADDR_WIDTH-1:0] r_y_addr;
    logic [MEM_ADDR_WIDTH-1:0] r_y_addr_bp;
    logic                      r_wr_bp;
    logic                      r_fifo_bp;

    logic                      w_y_wrap;
    logic [N_COEF-1:0]         w_tap_onehot;
    logic [CNT_W-1:0]          w_cnt_p1;
    logic [CNT_W-1:0]          w_ilen_m1;

    assign w_y_wrap     = (ylen != '0) && (CONFIG_WIDTH'(r_y_addr) == ylen - 1'b1);
    assign w_tap_onehot = N_COEF'(1) << r_tap;
    assign w_cnt_p1     = r_cnt + 1'b1;
    assign w_ilen_m1    = (ilen == '0) ? '0 : CNT_W'(ilen) - 1'b1;

    // r_tap/r_lch are M_addr split into tap and channel; the strobe registers
    // delay them one cycle to match the coefficient memory read latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_m_addr    <= '0;
            r_tap       <= '0;
            r_lch       <= '0;
            r_ld_m      <= '0;
            r_ld_ch     <= '0;
            r_ch_idx    <= '0;
            r_cnt       <= '0;
            r_y_addr    <= '0;
            r_y_addr_bp <= '0;
            r_wr_bp     <= 1'b0;
            r_fifo_bp   <= 1'b0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_m_addr    <= '0;
            r_tap       <= '0;
            r_lch       <= '0;
            r_ld_m      <= '0;
            r_ld_ch     <= '0;
            r_ch_idx    <= '0;
            r_cnt       <= '0;
            r_y_addr    <= '0;
            r_y_addr_bp <= '0;
            r_wr_bp     <= 1'b0;
            r_fifo_bp   <= 1'b0;
        end else begin
            r_fifo_bp   <= busy & ~Empty & ~Afull;
            r_wr_bp     <= Read_Enable;
            r_y_addr_bp <= r_m_addr;
            if (Write_Enable) begin
                r_y_addr <= w_y_wrap ? '0 : r_y_addr + 1'b1;
            end
            r_ld_m  <= (r_state == S_LOAD && !done) ? w_tap_onehot : '0;
            r_ld_ch <= (r_state == S_LOAD && !done) ? r_lch : '0;

            if (done) begin
                r_cnt    <= '0;
                r_ch_idx <= '0;
                if (r_state != S_IDLE) begin
                    r_state  <= S_IDLE;
                    r_m_addr <= '0;
                    r_tap    <= '0;
                    r_lch    <= '0;
                end else if (start) begin
                    r_state <= S_LOAD;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (r_m_addr == LP_M_LAST) begin
                            r_state <= S_LAST;
                        end else begin
                            r_m_addr <= r_m_addr + 1'b1;
                            if (r_tap == LP_TAP_LAST) begin
                                r_tap <= '0;
                                r_lch <= r_lch + 1'b1;
                            end else begin
                                r_tap <= r_tap + 1'b1;
                            end
                        end
                    end
                    S_LAST: r_state <= S_RUN;
                    S_RUN: begin
                        if (en_sum) begin
                            if (r_ch_idx == LP_CH_LAST) begin
                                r_ch_idx <= '0;
                                r_cnt    <= r_cnt + 1'b1;
                            end else begin
                                r_ch_idx <= r_ch_idx + 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign M_addr           = r_m_addr;
    assign ld_m             = r_ld_m;
    assign ld_ch            = r_ld_ch;
    assign coef_ready       = (r_state == S_RUN);
    assign ch_idx           = r_ch_idx;
    assign sel_xi           = (w_cnt_p1 >= LP_NCOEF) ? SEL_W'(N_COEF) : SEL_W'(w_cnt_p1);
    assign comp_cnt         = (r_cnt >= w_ilen_m1);
    assign Y_addr           = r_y_addr;
    assign Y_addr_bypass    = r_y_addr_bp;
    assign Write_bypass_mem = r_wr_bp;
    assign FIFO_bypass      = r_fifo_bp;

endmodule

// File: tb/tb_intpol2_dn_nxt_ste_lgc.sv
// tb/tb_intpol2_dn_nxt_ste_lgc.sv - self-checking bench against a timeline-level reference model
module tb_intpol2_dn_nxt_ste_lgc;

    localparam int NC  = 2;
    localparam int NT  = 3;
    localparam int AW  = 8;
    localparam int CW  = 16;
    localparam int NN  = NC * NT;
    localparam int CHW = 1;
    localparam int SW  = 2;

    logic clk = 1'b0;
    logic rstn, clear, start, busy, Empty, Afull, en_sum, Read_Enable, Write_Enable, done;
    logic [CW-1:0]  ilen, ylen;
    logic [AW-1:0]  M_addr, Y_addr, Y_addr_bypass;
    logic [NT-1:0]  ld_m;
    logic [CHW-1:0] ld_ch, ch_idx;
    logic [SW-1:0]  sel_xi;
    logic           coef_ready, comp_cnt, Write_bypass_mem, FIFO_bypass;

    intpol2_dn_nxt_ste_lgc #(
        .CONFIG_WIDTH(CW), .MEM_ADDR_WIDTH(AW), .NUM_CH(NC), .N_COEF(NT)
    ) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .start(start), .busy(busy),
        .Empty(Empty), .Afull(Afull), .en_sum(en_sum), .Read_Enable(Read_Enable),
        .Write_Enable(Write_Enable), .done(done), .ilen(ilen), .ylen(ylen),
        .M_addr(M_addr), .ld_m(ld_m), .ld_ch(ld_ch), .coef_ready(coef_ready),
        .ch_idx(ch_idx), .sel_xi(sel_xi), .comp_cnt(comp_cnt), .Y_addr(Y_addr),
        .Y_addr_bypass(Y_addr_bypass), .Write_bypass_mem(Write_bypass_mem),
        .FIFO_bypass(FIFO_bypass)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: m_k = cycles since the load began (saturating at RUN), m_e = en_sum events seen in RUN
    bit m_act;
    int m_k, m_e, m_y, m_yb;
    bit m_fb, m_wb;

    function automatic int exp_maddr();
        return m_act ? ((m_k < NN - 1) ? m_k : NN - 1) : 0;
    endfunction

    task automatic model_reset();
        m_act = 0; m_k = 0; m_e = 0; m_y = 0; m_yb = 0; m_fb = 0; m_wb = 0;
    endtask

    task automatic model_edge();
        int ma;
        if (clear) begin
            model_reset();
        end else begin
            ma   = exp_maddr();
            m_fb = busy & ~Empty & ~Afull;
            m_wb = Read_Enable;
            m_yb = ma;
            if (Write_Enable)
                m_y = (ylen != 0 && m_y == int'(ylen) - 1) ? 0 : (m_y + 1) % (1 << AW);
            if (done) begin
                m_e = 0;
                if (m_act) begin m_act = 0; m_k = 0; end
                else if (start) begin m_act = 1; m_k = 0; end
            end else if (!m_act) begin
                if (start) begin m_act = 1; m_k = 0; end
            end else if (m_k < NN + 1) begin
                m_k++;
            end else if (en_sum) begin
                m_e++;
            end
        end
    endtask

    task automatic check_all(input string ph);
        int cnt, il1, sel, ldm, ldc;
        cnt = m_e / NC;
        il1 = (ilen == 0) ? 1 : int'(ilen);
        sel = (cnt + 1 < NT) ? cnt + 1 : NT;
        ldm = (m_act && m_k >= 1 && m_k <= NN) ? (1 << ((m_k - 1) % NT)) : 0;
        ldc = (m_act && m_k >= 1 && m_k <= NN) ? ((m_k - 1) / NT) : 0;
        check({ph, ".M_addr"}, M_addr, exp_maddr());
        check({ph, ".ld_m"}, ld_m, ldm);
        check({ph, ".ld_ch"}, ld_ch, ldc);
        check({ph, ".coef_ready"}, coef_ready, (m_act && m_k == NN + 1));
        check({ph, ".ch_idx"}, ch_idx, m_e % NC);
        check({ph, ".sel_xi"}, sel_xi, sel);
        check({ph, ".comp_cnt"}, comp_cnt, (cnt >= il1 - 1));
        check({ph, ".Y_addr"}, Y_addr, m_y);
        check({ph, ".Y_addr_bypass"}, Y_addr_bypass, m_yb);
        check({ph, ".Write_bypass_mem"}, Write_bypass_mem, m_wb);
        check({ph, ".FIFO_bypass"}, FIFO_bypass, m_fb);
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic idle_inputs();
        clear = 0; start = 0; busy = 0; Empty = 1; Afull = 0; en_sum = 0;
        Read_Enable = 0; Write_Enable = 0; done = 0;
    endtask

    logic [NT-1:0] ldm_tab [7];
    logic [AW-1:0] y_tab   [7];
    logic [7:0]    ylen_set[4];

    initial begin
        ldm_tab  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
        y_tab    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2};
        ylen_set = '{8'd0, 8'd3, 8'd5, 8'd7};
        rstn = 0; idle_inputs(); ilen = 4; ylen = 0;
        model_reset();

        // reset held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            {start, busy, Empty, Afull, en_sum, Read_Enable, Write_Enable, done, clear} = 9'($urandom);
            ilen = CW'(2 + $urandom % 5);
            ylen = CW'($urandom);
            #7;
            check_all("reset");
            check("reset.sel_xi_one", sel_xi, 1);
        end
        @(negedge clk);
        idle_inputs(); ylen = 0; ilen = 4;
        rstn = 1;
        step("idle");
        step("idle");

        // coefficient load
        start = 1; step("load_start"); start = 0;
        check("load.M_addr0", M_addr, 0);
        for (int k = 1; k <= 7; k++) begin
            step("load");
            check($sformatf("load.ld_m%0d", k), ld_m, ldm_tab[k-1]);
            check($sformatf("load.ld_ch%0d", k), ld_ch, (k >= 1 && k <= 6) ? (k - 1) / 3 : 0);
            check($sformatf("load.coef_ready%0d", k), coef_ready, k == 7);
        end

        // run counting, then done beating en_sum
        en_sum = 1;
        for (int i = 0; i < 9; i++) step("run");
        check("run.comp_cnt_hi", comp_cnt, 1);
        check("run.sel_xi_sat", sel_xi, 3);
        done = 1; step("done"); done = 0; en_sum = 0;
        check("done.coef_ready", coef_ready, 0);
        check("done.sel_xi", sel_xi, 1);

        // Y wrap with ylen=5
        clear = 1; step("clr"); clear = 0;
        ylen = 5; Write_Enable = 1;
        for (int i = 0; i < 7; i++) begin
            step("ywrap");
            check($sformatf("ywrap.Y%0d", i), Y_addr, y_tab[i]);
        end
        // natural wrap with ylen=0
        Write_Enable = 0; ylen = 0; clear = 1; step("clr"); clear = 0;
        Write_Enable = 1;
        for (int i = 0; i < 255; i++) step("yfull");
        check("yfull.Y_max", Y_addr, 8'hFF);
        step("yfull");
        check("yfull.Y_zero", Y_addr, 0);
        Write_Enable = 0;

        // bypass
        busy = 1; Empty = 0;
        Afull = 0; step("byp"); check("byp.fifo0", FIFO_bypass, 1);
        Afull = 1; step("byp"); check("byp.fifo1", FIFO_bypass, 0);
        Afull = 0; step("byp"); check("byp.fifo2", FIFO_bypass, 1);
        start = 1; step("byp_ld"); start = 0;
        step("byp_ld");
        Read_Enable = 1; step("byp_re"); Read_Enable = 0;
        check("byp.wr_bp", Write_bypass_mem, 1);
        check("byp.y_bp", Y_addr_bypass, 1);
        step("byp_re");
        check("byp.wr_bp_off", Write_bypass_mem, 0);

        // clear mid-load, with start arriving alongside clear
        clear = 1; step("clr"); clear = 0;
        start = 1; step("cl_ld"); start = 0;
        for (int i = 0; i < 3; i++) step("cl_ld");
        check("clr.M_addr3", M_addr, 3);
        clear = 1; start = 1; step("clr_mid"); clear = 0; start = 0;
        check("clr.M_addr", M_addr, 0);
        check("clr.ld_m", ld_m, 0);
        step("clr_after");
        check("clr.start_ignored", M_addr, 0);

        // async reset mid-load
        start = 1; step("rs_ld"); start = 0;
        step("rs_ld"); step("rs_ld");
        #2 rstn = 0; model_reset();
        #1 check_all("arst");
        @(negedge clk); rstn = 1;
        step("arst_rel");
        step("arst_rel");
        check("arst.no_load", M_addr, 0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            start        = ($urandom % 6) == 0;
            done         = ($urandom % 30) == 0;
            clear        = ($urandom % 80) == 0;
            en_sum       = $urandom % 2;
            Write_Enable = ($urandom % 3) == 0;
            Read_Enable  = $urandom % 2;
            busy         = $urandom % 2;
            Empty        = $urandom % 2;
            Afull        = $urandom % 2;
            if (c % 50 == 0) begin
                ilen = CW'($urandom % 7);
                ylen = CW'(ylen_set[$urandom % 4]);
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/intpol2_dn_nxt_ste_lgc.md
# intpol2_dn_nxt_ste_lgc

Parametrised next-state/sequencing logic for the multi-channel interpolator datapath. It does three things:
- Fetches NUM_CH×N_COEF coefficients from the M memory and steers them into per-channel/per-tap registers.
- Tracks the interleaved channel index and sample count against `ilen`, and generates the output-memory write address with programmable wrap.
- Drives a registered FIFO bypass path.

It sits between the interpolator control FSM and the datapath/memories. It generalises the 3-tap single-channel sequencer to arbitrary tap and channel counts, and adds explicit load/run states.

## Interface
- CONFIG_WIDTH, 32, width of `ilen`/`ylen` configuration words
- MEM_ADDR_WIDTH, 16, M/Y memory address width
- NUM_CH, 2, interleaved channel count (≥1)
- N_COEF, 3, coefficients (taps) per channel (≥2)
- CH_W, clog2(NUM_CH) (min 1), channel index width
- SEL_W, clog2(N_COEF+1), tap-select width

Ports:
- clk  in  1  clock; single clock domain
- rstn  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear; highest priority after reset
- start  in  1  begin coefficient load (honoured in IDLE only)
- busy  in  1  interpolator active
- Empty  in  1  input FIFO empty
- Afull  in  1  output FIFO almost full
- en_sum  in  1  one channel-sample accumulated
- Read_Enable  in  1  M memory read strobe from control
- Write_Enable  in  1  Y memory write strobe
- done  in  1  end of block
- ilen  in  CONFIG_WIDTH  samples per channel per block
- ylen  in  CONFIG_WIDTH  Y buffer length; 0 = full 2^MEM_ADDR_WIDTH
- M_addr  out  MEM_ADDR_WIDTH  coefficient memory address
- ld_m  out  N_COEF  one-hot tap load strobe
- ld_ch  out  CH_W  channel of current `ld_m`
- coef_ready  out  1  high in RUN
- ch_idx  out  CH_W  current interleaved channel
- sel_xi  out  SEL_W  tap-history select
- comp_cnt  out  1  last sample of block reached
- Y_addr  out  MEM_ADDR_WIDTH  Y write address
- Y_addr_bypass  out  MEM_ADDR_WIDTH  M_addr delayed one cycle
- Write_bypass_mem  out  1  Read_Enable delayed one cycle
- FIFO_bypass  out  1  registered bypass enable

## Operation
- **States:** IDLE, LOAD, LAST, RUN. Reset/clear → IDLE.
- **IDLE:**
  - `start` → LOAD.
  - M_addr = 0.
- **LOAD:**
  - M_addr increments by 1 every cycle.
  - When M_addr = NUM_CH·N_COEF−1, go to LAST (no further increment).
- **LAST:** one cycle, then RUN.
- **Tap/channel strobes:**
  - In LOAD and LAST, the previous cycle's address a (memory latency 1) drives:
    - `ld_m` one-hot bit (a mod N_COEF)
    - `ld_ch` = a div N_COEF
  - Otherwise `ld_m` = 0.
- **RUN:**
  - `coef_ready` = 1.
  - `en_sum` advances ch_idx; wrap NUM_CH−1 → 0.
  - On that wrap, sample counter cnt (CONFIG_WIDTH+1 bits) increments.
- **done:**
  - cnt and ch_idx clear, state → IDLE.
  - `done` beats `en_sum` in the same cycle.
  - In IDLE it clears the counters only.
- **Combinational outputs:**
  - `sel_xi` = min(cnt+1, N_COEF).
  - `comp_cnt` = (cnt ≥ ilen−1); ilen = 0 treated as 1.
- **Y_addr:**
  - Increments on `Write_Enable` in any state.
  - When ylen≠0 and Y_addr = ylen−1, it wraps to 0.
  - Persists across `done`; only reset/clear zero it.
- **Bypass registers:**
  - FIFO_bypass ← busy & ~Empty & ~Afull.
  - Write_bypass_mem ← Read_Enable.
  - Y_addr_bypass ← M_addr.
- **Ignored inputs:**
  - `start` outside IDLE.
  - `en_sum` outside RUN.

## Timing
- Reset (async, rstn low) and clear (sync) both drive:
  - every register 0
  - state IDLE
  - all outputs 0
  - sel_xi = 1, since cnt = 0
- Clear applies on the next clk edge and overrides all inputs.
- start at edge 0 → LOAD. M_addr sequence: 1,2,…,NUM_CH·N_COEF−1.
- RUN is reached NUM_CH·N_COEF+1 cycles after start. `ld_m` pulses NUM_CH·N_COEF times, once per cycle.
- All bypass outputs lag their source by exactly 1 cycle.
- comp_cnt, sel_xi, ld_m, ld_ch, coef_ready are combinational from registers, with no input-to-output combinational path.
- Counter widths:
  - cnt never wraps within a legal block (ilen < 2^CONFIG_WIDTH).
  - Y_addr with ylen = 0 wraps naturally mod 2^MEM_ADDR_WIDTH.
- Reset mid-LOAD abandons the load. A new `start` is required.

## Test plan
- **Reset values:** NUM_CH=2, N_COEF=3; hold rstn low, toggle inputs → all outputs 0 except sel_xi=1. Release rstn → IDLE, M_addr=0.
- **Coefficient load:** start → M_addr 0..5.
  - ld_m = 001,010,100,001,010,100 with ld_ch = 0,0,0,1,1,1 on cycles 1..6.
  - coef_ready rises on cycle 7.
- **Run counting:** RUN, ilen=4, en_sum every cycle.
  - ch_idx toggles 0,1,0,1…
  - cnt increments every 2 en_sum.
  - sel_xi = 1,2,3,3.
  - comp_cnt rises when cnt=3.
  - done with en_sum same cycle → cnt=0, IDLE.
- **Y wrap:** ylen=5, 7 Write_Enable pulses → Y_addr 1,2,3,4,0,1,2. With ylen=0 from 0xFFFF, one pulse → 0x0000.
- **Bypass:** busy=1, Empty=0, Afull toggling 0,1,0 → FIFO_bypass 1,0,1 one cycle later. A Read_Enable pulse → Write_bypass_mem pulse next cycle with Y_addr_bypass = prior M_addr.
- **Clear mid-operation:** clear in LOAD at M_addr=3 → next cycle IDLE, M_addr=0, ld_m=0. A start arriving with clear is ignored.
